// File: rtl/param_memory.sv
// Byte-addressed big-endian unified memory with an instruction-fetch port and a
// data load/store port, each behind its own fixed-latency req/valid FSM.
module param_memory #(
    parameter int    ADDR_W    = 20,
    parameter int    INS_LAT   = 4,
    parameter int    DATA_LAT  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insReq,
    input  logic [31:0] insAdd,
    output logic [31:0] insData,
    output logic        insValid,
    output logic        insErr,
    input  logic        dataReq,
    input  logic        dataWrite,
    input  logic [1:0]  dataSize,
    input  logic [31:0] dataAdd,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        dataValid,
    output logic        dataErr,
    output logic        memStall
);
    localparam int ICW   = (INS_LAT > 1) ? $clog2(INS_LAT) : 1;
    localparam int DCW   = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0] mem [DEPTH];

    // ---------------- instruction-fetch port ----------------
    state_t            ins_state, ins_next;
    logic [ICW-1:0]    ins_cnt;
    logic [ADDR_W-1:0] ins_addr_q, i_addr;
    logic [ADDR_W-3:0] i_base;
    logic              ins_commit, i_err;
    logic [31:0]       i_word, fwd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ins_state <= IDLE;
        else        ins_state <= ins_next;
    end

    always_comb begin
        ins_next = ins_state;
        case (ins_state)
            IDLE:    if (insReq) ins_next = (INS_LAT > 1) ? WAIT : RESP;
            WAIT:    if (ins_cnt == ICW'(1)) ins_next = RESP;
            RESP:    ins_next = IDLE;
            default: ins_next = IDLE;
        endcase
    end

    always_comb begin
        insValid = (ins_state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_cnt    <= '0;
            ins_addr_q <= '0;
        end else if (ins_state == IDLE && insReq) begin
            ins_cnt    <= ICW'(INS_LAT - 1);
            ins_addr_q <= insAdd[ADDR_W-1:0];
        end else if (ins_state == WAIT) begin
            ins_cnt    <= ins_cnt - 1'b1;
        end
    end

    // With latency 1 the commit edge is also the capture edge, so use live inputs.
    assign i_addr     = (ins_state == IDLE) ? insAdd[ADDR_W-1:0] : ins_addr_q;
    assign i_base     = i_addr[ADDR_W-1:2];
    assign i_err      = (i_addr[1:0] != 2'b00);
    assign ins_commit = (ins_next == RESP) && (ins_state != RESP);
    assign i_word     = {mem[{i_base, 2'd0}], mem[{i_base, 2'd1}],
                         mem[{i_base, 2'd2}], mem[{i_base, 2'd3}]};

    // ---------------- data load/store port ----------------
    state_t            data_state, data_next;
    logic [DCW-1:0]    data_cnt;
    logic [ADDR_W-1:0] data_addr_q, d_addr;
    logic [1:0]        data_size_q, d_size;
    logic              data_write_q, d_write;
    logic [31:0]       data_in_q, d_in;
    logic [ADDR_W-3:0] d_base;
    logic              data_commit, store_commit, d_err;
    logic [31:0]       d_word, load_val, wr_word;
    logic [3:0]        wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_state <= IDLE;
        else        data_state <= data_next;
    end

    always_comb begin
        data_next = data_state;
        case (data_state)
            IDLE:    if (dataReq) data_next = (DATA_LAT > 1) ? WAIT : RESP;
            WAIT:    if (data_cnt == DCW'(1)) data_next = RESP;
            RESP:    data_next = IDLE;
            default: data_next = IDLE;
        endcase
    end

    always_comb begin
        dataValid = (data_state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt     <= '0;
            data_addr_q  <= '0;
            data_size_q  <= '0;
            data_write_q <= 1'b0;
            data_in_q    <= '0;
        end else if (data_state == IDLE && dataReq) begin
            data_cnt     <= DCW'(DATA_LAT - 1);
            data_addr_q  <= dataAdd[ADDR_W-1:0];
            data_size_q  <= dataSize;
            data_write_q <= dataWrite;
            data_in_q    <= dataIn;
        end else if (data_state == WAIT) begin
            data_cnt     <= data_cnt - 1'b1;
        end
    end

    assign d_addr       = (data_state == IDLE) ? dataAdd[ADDR_W-1:0] : data_addr_q;
    assign d_size       = (data_state == IDLE) ? dataSize : data_size_q;
    assign d_write      = (data_state == IDLE) ? dataWrite : data_write_q;
    assign d_in         = (data_state == IDLE) ? dataIn : data_in_q;
    assign d_base       = d_addr[ADDR_W-1:2];
    assign d_err        = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0])
                       || (d_size == 2'b10 && d_addr[1:0] != 2'b00);
    assign data_commit  = (data_next == RESP) && (data_state != RESP);
    assign store_commit = data_commit && d_write && !d_err;
    assign d_word       = {mem[{d_base, 2'd0}], mem[{d_base, 2'd1}],
                           mem[{d_base, 2'd2}], mem[{d_base, 2'd3}]};

    // Lane i (bit 3-i of wr_en) is byte offset i, i.e. word bits [31-8i -: 8].
    always_comb begin
        wr_en   = '0;
        wr_word = '0;
        case (d_size)
            2'b00: begin
                wr_en   = 4'b1000 >> d_addr[1:0];
                wr_word = {4{d_in[7:0]}};
            end
            2'b01: begin
                wr_en   = d_addr[1] ? 4'b0011 : 4'b1100;
                wr_word = {2{d_in[15:0]}};
            end
            2'b10: begin
                wr_en   = 4'b1111;
                wr_word = d_in;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (d_size)
            2'b00:   load_val = {24'b0, d_word[{~d_addr[1:0], 3'b000} +: 8]};
            2'b01:   load_val = {16'b0, d_word[{~d_addr[1], 4'b0000} +: 16]};
            2'b10:   load_val = d_word;
            default: load_val = '0;
        endcase
    end

    // A store committing on the same edge as a fetch is forwarded into the fetch word.
    always_comb begin
        fwd_word = i_word;
        if (store_commit && d_base == i_base) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_en[3-i]) fwd_word[31-8*i -: 8] = wr_word[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_en[3-i]) mem[{d_base, 2'(i)}] <= wr_word[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insData <= '0;
            insErr  <= 1'b0;
        end else if (ins_commit) begin
            insErr  <= i_err;
            insData <= i_err ? '0 : fwd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataOut <= '0;
            dataErr <= 1'b0;
        end else if (data_commit) begin
            dataErr <= d_err;
            dataOut <= (d_err || d_write) ? '0 : load_val;
        end
    end

    always_comb begin
        memStall = (ins_state != IDLE) || (data_state != IDLE) || insReq || dataReq;
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^{insAdd[31:ADDR_W], dataAdd[31:ADDR_W]};

endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: directed scenarios plus randomized data-port traffic
// checked against a byte-array reference model.
module tb_param_memory;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u0: default latencies (4/4)
    logic        ins_req = 0, data_req = 0, data_write = 0;
    logic [31:0] ins_add = 0, data_add = 0, data_in = 0;
    logic [1:0]  data_size = 0;
    logic [31:0] ins_data, data_out;
    logic        ins_valid, ins_err, data_valid, data_err, mem_stall;
    // u1: latencies 2/2 for same-edge forwarding
    logic        f_ins_req = 0, f_data_req = 0, f_data_write = 0;
    logic [31:0] f_ins_add = 0, f_data_add = 0, f_data_in = 0;
    logic [1:0]  f_data_size = 0;
    logic [31:0] f_ins_data, f_data_out;
    logic        f_ins_valid, f_ins_err, f_data_valid, f_data_err, f_mem_stall;

    param_memory #(.ADDR_W(20), .INS_LAT(4), .DATA_LAT(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .insReq(ins_req), .insAdd(ins_add), .insData(ins_data), .insValid(ins_valid), .insErr(ins_err),
        .dataReq(data_req), .dataWrite(data_write), .dataSize(data_size), .dataAdd(data_add),
        .dataIn(data_in), .dataOut(data_out), .dataValid(data_valid), .dataErr(data_err),
        .memStall(mem_stall));

    param_memory #(.ADDR_W(20), .INS_LAT(2), .DATA_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .insReq(f_ins_req), .insAdd(f_ins_add), .insData(f_ins_data), .insValid(f_ins_valid), .insErr(f_ins_err),
        .dataReq(f_data_req), .dataWrite(f_data_write), .dataSize(f_data_size), .dataAdd(f_data_add),
        .dataIn(f_data_in), .dataOut(f_data_out), .dataValid(f_data_valid), .dataErr(f_data_err),
        .memStall(f_mem_stall));

    int checks = 0;
    int failures = 0;

    // Reference model: bytes keyed by the 20-bit alias of the address.
    bit [7:0] ref_mem [int unsigned];

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v = 0;
        if (model_err(sz, a)) return 0;
        for (int unsigned j = 0; j < nbytes(sz); j++)
            v = (v << 8) | 32'(ref_mem[(a + j) % (1 << 20)]);
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned n = nbytes(sz);
        if (model_err(sz, a)) return;
        for (int unsigned j = 0; j < n; j++)
            ref_mem[(a + j) % (1 << 20)] = 8'((d >> (8 * (n - 1 - j))) & 32'hFF);
    endfunction

    // Returns lat = number of edges from the sampling edge (counted as 1) until valid; 0 on timeout.
    task automatic data_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] out, output logic err,
                               output int lat);
        @(negedge clk);
        if (data_valid) @(negedge clk);
        data_req = 1; data_write = w; data_size = sz; data_add = a; data_in = d;
        lat = 0; out = 0; err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) data_req = 0;
            if (data_valid) begin lat = k; out = data_out; err = data_err; break; end
        end
        data_req = 0;
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] out, output logic err, output int lat);
        @(negedge clk);
        if (ins_valid) @(negedge clk);
        ins_req = 1; ins_add = a;
        lat = 0; out = 0; err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) ins_req = 0;
            if (ins_valid) begin lat = k; out = ins_data; err = ins_err; break; end
        end
        ins_req = 0;
    endtask

    task automatic test_reset;
        logic [31:0] o; logic e; int l; bit seen;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ins_data, ins_valid, ins_err, data_out, data_valid, data_err, mem_stall} !== '0) begin
            failures++; $display("FAIL reset_u0: outputs=%h required 0",
                {ins_data, ins_valid, ins_err, data_out, data_valid, data_err, mem_stall});
        end
        checks++;
        if ({f_ins_data, f_ins_valid, f_ins_err, f_data_out, f_data_valid, f_data_err, f_mem_stall} !== '0) begin
            failures++; $display("FAIL reset_u1: outputs nonzero");
        end
        rst_n = 1;
        data_access(1, 2'b10, 32'h300, 32'hCAFEF00D, o, e, l);
        data_access(0, 2'b10, 32'h300, 0, o, e, l);
        checks++;
        if (o !== 32'hCAFEF00D) begin failures++; $display("FAIL reset_preload: got %h required cafef00d", o); end
        // Start a store, then reset while it is waiting.
        @(negedge clk); @(negedge clk);
        data_req = 1; data_write = 1; data_size = 2'b10; data_add = 32'h300; data_in = 32'h11111111;
        @(posedge clk); #1 data_req = 0;
        @(posedge clk); #1;
        checks++;
        if (mem_stall !== 1'b1) begin failures++; $display("FAIL reset_busy_stall: got %b required 1", mem_stall); end
        rst_n = 0; #1;
        checks++;
        if ({data_out, data_valid, data_err, ins_data, ins_valid, ins_err, mem_stall} !== '0) begin
            failures++; $display("FAIL reset_midwait: outputs=%h required 0",
                {data_out, data_valid, data_err, ins_data, ins_valid, ins_err, mem_stall});
        end
        @(negedge clk); rst_n = 1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (data_valid) seen = 1; end
        checks++;
        if (seen || mem_stall !== 1'b0) begin
            failures++; $display("FAIL reset_dropped: valid_seen=%b stall=%b required 0 0", seen, mem_stall);
        end
        data_access(0, 2'b10, 32'h300, 0, o, e, l);
        checks++;
        if (o !== 32'hCAFEF00D) begin failures++; $display("FAIL reset_retained: got %h required cafef00d", o); end
    endtask

    task automatic test_latency;
        logic [31:0] o; logic e; int l;
        data_access(1, 2'b10, 32'h100, 32'hDEADBEEF, o, e, l);
        checks++;
        if (l !== 4 || e !== 1'b0) begin failures++; $display("FAIL store_latency: lat=%0d err=%b required 4 0", l, e); end
        data_access(0, 2'b10, 32'h100, 0, o, e, l);
        checks++;
        if (l !== 4) begin failures++; $display("FAIL load_latency: lat=%0d required 4", l); end
        checks++;
        if (o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_word: got %h required deadbeef", o); end
        @(posedge clk); #1;
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse: got %b required 0", data_valid); end
    endtask

    task automatic test_byte_half;
        logic [31:0] o; logic e; int l;
        data_access(1, 2'b00, 32'h103, 32'hFFFFFF5A, o, e, l);
        data_access(0, 2'b10, 32'h100, 0, o, e, l);
        checks++;
        if (o !== 32'hDEADBE5A) begin failures++; $display("FAIL byte_store: got %h required deadbe5a", o); end
        data_access(0, 2'b01, 32'h102, 0, o, e, l);
        checks++;
        if (o !== 32'h0000BE5A) begin failures++; $display("FAIL half_load: got %h required 0000be5a", o); end
        data_access(1, 2'b01, 32'h100, 32'hABCD1234, o, e, l);
        data_access(0, 2'b10, 32'h100, 0, o, e, l);
        checks++;
        if (o !== 32'h1234BE5A) begin failures++; $display("FAIL half_store: got %h required 1234be5a", o); end
        data_access(0, 2'b00, 32'h101, 0, o, e, l);
        checks++;
        if (o !== 32'h00000034) begin failures++; $display("FAIL byte_load: got %h required 00000034", o); end
    endtask

    task automatic test_misaligned;
        logic [31:0] o; logic e; int l;
        data_access(1, 2'b10, 32'h102, 32'h0BADF00D, o, e, l);
        checks++;
        if (e !== 1'b1 || o !== 32'h0 || l !== 4) begin
            failures++; $display("FAIL misaligned_word: err=%b out=%h lat=%0d required 1 0 4", e, o, l);
        end
        data_access(1, 2'b01, 32'h103, 32'hFFFF, o, e, l);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL misaligned_half: err=%b required 1", e); end
        data_access(0, 2'b11, 32'h100, 0, o, e, l);
        checks++;
        if (e !== 1'b1 || o !== 32'h0) begin failures++; $display("FAIL illegal_size: err=%b out=%h required 1 0", e, o); end
        data_access(0, 2'b10, 32'h100, 0, o, e, l);
        checks++;
        if (o !== 32'h1234BE5A || e !== 1'b0) begin
            failures++; $display("FAIL misaligned_nowrite: got %h err=%b required 1234be5a 0", o, e);
        end
    endtask

    task automatic test_forwarding;
        logic [1:0]  sz [2]  = '{2'b10, 2'b00};
        logic [31:0] ad [2]  = '{32'h200, 32'h201};
        logic [31:0] dv [2]  = '{32'h12345678, 32'h000000AB};
        logic [31:0] exp [2] = '{32'h12345678, 32'h12AB5678};
        int il, dl; logic [31:0] o;
        for (int t = 0; t < 2; t++) begin
            repeat (2) @(negedge clk);
            f_data_req = 1; f_data_write = 1; f_data_size = sz[t]; f_data_add = ad[t]; f_data_in = dv[t];
            f_ins_req = 1; f_ins_add = 32'h200;
            il = 0; dl = 0; o = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                if (k == 1) begin f_data_req = 0; f_ins_req = 0; end
                if (f_ins_valid && il == 0) begin il = k; o = f_ins_data; end
                if (f_data_valid && dl == 0) dl = k;
            end
            checks++;
            if (il !== 2 || dl !== 2) begin failures++; $display("FAIL fwd_latency%0d: ins=%0d data=%0d required 2 2", t, il, dl); end
            checks++;
            if (o !== exp[t]) begin failures++; $display("FAIL fwd_data%0d: got %h required %h", t, o, exp[t]); end
        end
    endtask

    task automatic test_stall_wrap;
        logic [31:0] o, d1, d2; logic e; int l, v1, v2, highs;
        data_access(1, 2'b10, 32'h0, 32'hA5A5C3C3, o, e, l);
        repeat (2) @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b required 0", mem_stall); end
        ins_add = 32'hFFF00000; ins_req = 1; #1;
        checks++;
        if (mem_stall !== 1'b1) begin failures++; $display("FAIL stall_req: got %b required 1", mem_stall); end
        v1 = 0; v2 = 0; highs = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (ins_valid) begin
                highs++;
                if (v1 == 0) begin v1 = k; d1 = ins_data; end
                else begin v2 = k; d2 = ins_data; break; end
            end
        end
        ins_req = 0;
        checks++;
        if (v1 !== 4 || v2 !== 9 || highs !== 2) begin
            failures++; $display("FAIL back_to_back: v1=%0d v2=%0d pulses=%0d required 4 9 2", v1, v2, highs);
        end
        checks++;
        if (d1 !== 32'hA5A5C3C3 || d2 !== 32'hA5A5C3C3) begin
            failures++; $display("FAIL fetch_alias: got %h %h required a5a5c3c3", d1, d2);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_stall !== 1'b0 || ins_valid !== 1'b0) begin
            failures++; $display("FAIL stall_release: stall=%b valid=%b required 0 0", mem_stall, ins_valid);
        end
        fetch(32'h00000102, o, e, l);
        checks++;
        if (e !== 1'b1 || o !== 32'h0 || l !== 4) begin
            failures++; $display("FAIL fetch_misaligned: err=%b data=%h lat=%0d required 1 0 4", e, o, l);
        end
        data_access(0, 2'b10, 32'hFFF00000, 0, o, e, l);
        checks++;
        if (o !== 32'hA5A5C3C3) begin failures++; $display("FAIL data_alias: got %h required a5a5c3c3", o); end
    endtask

    task automatic test_random;
        logic [31:0] o, a, d, exp; logic e, w; logic [1:0] sz; int l; bit ee;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            a = 32'h1000 + 32'(4 * i);
            model_store(2'b10, a, d);
            data_access(1, 2'b10, a, d, o, e, l);
        end
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            a  = (32'h1000 + $urandom_range(0, 255)) | ($urandom & 32'hFFF00000);
            ee = model_err(sz, a);
            exp = (w || ee) ? 32'h0 : model_load(sz, a);
            if (w) model_store(sz, a, d);
            data_access(w, sz, a, d, o, e, l);
            checks++;
            if (l !== 4 || e !== ee) begin
                failures++; $display("FAIL rand_resp%0d: lat=%0d err=%b required 4 %b", i, l, e, ee);
            end
            if (!w || ee) begin
                checks++;
                if (o !== exp) begin
                    failures++; $display("FAIL rand_data%0d: sz=%0d a=%h got %h required %h", i, sz, a, o, exp);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_byte_half();
        test_misaligned();
        test_forwarding();
        test_stall_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
